fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter QDEPTH, default 2: prefetch queue entries; the only legal value is 2.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 imem_addr  output  32  byte address to instruction memory; always equals fetch_pc.
REQ-007 imem_en  output  1  high in a cycle where the fetch is committed.
REQ-008 imem_rdata  input  32  combinational instruction word for imem_addr, valid in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-010 redirect_pc  input  32  redirect target byte address.
REQ-011 halt  input  1  level request to stop fetching.
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_instr  output  32  instruction at the queue head.
REQ-014 out_pc  output  32  byte address of out_instr.
REQ-015 out_ready  input  1  downstream accepts the head this cycle.
REQ-016 misalign_err  output  1  sticky flag for a misaligned redirect target.

Function
REQ-017 There SHALL be 3 states: RUN, HALT, ERR.
- RUN -> HALT when halt=1.
- HALT -> RUN when halt=0.
- RUN/HALT -> ERR on a misaligned redirect.
- ERR is left only by reset.
REQ-018 The fetch condition is fetch_ok = (state==RUN) & !halt & !redirect_valid & (count<2 | pop). imem_en SHALL equal fetch_ok.
REQ-019 When fetch_ok=1, the clock edge SHALL push {fetch_pc, imem_rdata} into the queue tail and set fetch_pc <= fetch_pc+4.
REQ-020 The fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); the controller SHALL NOT flag addresses beyond memory size.
REQ-021 pop = out_valid & out_ready; a pop SHALL remove the head at the clock edge.
REQ-022 Push and pop in the same edge SHALL leave count unchanged and preserve order.
REQ-023 Fetch-to-output latency SHALL be 1 cycle: a word fetched at edge N is visible at out_* after edge N if the queue was empty.
REQ-024 out_valid SHALL equal (count!=0); out_instr and out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Aligned redirect (redirect_pc[1:0]==0) in RUN or HALT:
- the edge SHALL flush the queue (count=0) and set fetch_pc <= redirect_pc;
- no fetch occurs in that cycle;
- a simultaneous pop is consumed, then the flush applies;
- state is unchanged.
REQ-026 Misaligned redirect (redirect_pc[1:0]!=0) in RUN or HALT SHALL flush the queue, leave fetch_pc unchanged, set misalign_err=1 and enter ERR.
REQ-027 In ERR: imem_en=0, out_valid=0, redirects ignored, misalign_err held at 1.
REQ-028 halt SHALL take effect combinationally: imem_en=0 in the same cycle halt=1. Queued entries SHALL still drain via out_ready.

Reset
REQ-029 While reset=1 at an edge: state<=RUN, fetch_pc<=RESET_PC, count<=0, misalign_err<=0, stored queue data<=0.
REQ-030 imem_en SHALL be 0 in any cycle where reset=1.
REQ-031 After reset: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries and override redirect, halt and pop in the same cycle.

Structure
REQ-033 The shared package cpu_pkg SHALL hold: the fetch state enum (RUN/HALT/ERR), INSTR_W=32, ADDR_W=32 and the default RESET_PC.
REQ-034 The queue SHALL be a sub-module fetch_queue: 2-entry FIFO of {pc, instr} with push/pop/flush/count.
REQ-035 fetch_controller SHALL hold the FSM, the fetch_pc register and the fetch/redirect logic.

Verification
REQ-036 Reset, out_ready=1, memory word i = 32'hA000_0000+i -> edge 1: out_pc=0, out_instr=A0000000; thereafter one instruction per cycle, out_pc=0,4,8,...
REQ-037 out_ready=0 for 5 cycles -> count reaches 2 after 2 fetches; imem_en=0; imem_addr=0x8 holds; out_pc=0 stable.
REQ-038 Redirect to 0x100 while count=2 with out_ready=1 -> head consumed, queue flushed; next out_pc=0x100 with instr=mem[64]; no stale 0x8 delivered.
REQ-039 Redirect to 0x102 -> misalign_err=1, out_valid=0, imem_en=0; a later aligned redirect is ignored; reset clears the flag.
REQ-040 halt=1 for 3 cycles with 2 entries queued and out_ready=1 -> both entries drain; no fetch; resume at the next sequential PC when halt drops.
REQ-041 Redirect to 0xFFFF_FFFC, run -> out_pc=FFFFFFFC then 0x0000_0000 (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
// Holds the fetch FSM state encoding and datapath widths.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {pc, instr}.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [1:0]         o_count,
    output logic               o_full
);

    localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

    logic [ADDR_W-1:0]  r_pc0;
    logic [ADDR_W-1:0]  r_pc1;
    logic [INSTR_W-1:0] r_in0;
    logic [INSTR_W-1:0] r_in1;
    logic [1:0]         r_cnt;

    logic [ADDR_W-1:0]  w_pc0_nxt;
    logic [ADDR_W-1:0]  w_pc1_nxt;
    logic [INSTR_W-1:0] w_in0_nxt;
    logic [INSTR_W-1:0] w_in1_nxt;
    logic [1:0]         w_cnt_nxt;
    logic [1:0]         w_cnt_after_pop;

    // Next entry contents and occupancy: pop shifts first, then push fills
    // the first free slot, so a push+pop at full keeps FIFO order.
    always_comb begin
        w_pc0_nxt = r_pc0;
        w_pc1_nxt = r_pc1;
        w_in0_nxt = r_in0;
        w_in1_nxt = r_in1;
        w_cnt_after_pop = r_cnt;
        if (i_pop && r_cnt != 2'd0) begin
            w_pc0_nxt = r_pc1;
            w_in0_nxt = r_in1;
            w_cnt_after_pop = r_cnt - 2'd1;
        end
        w_cnt_nxt = w_cnt_after_pop;
        if (i_push && w_cnt_after_pop != LP_DEPTH) begin
            if (w_cnt_after_pop == 2'd0) begin
                w_pc0_nxt = i_pc;
                w_in0_nxt = i_instr;
            end else begin
                w_pc1_nxt = i_pc;
                w_in1_nxt = i_instr;
            end
            w_cnt_nxt = w_cnt_after_pop + 2'd1;
        end
        if (i_flush) begin
            w_cnt_nxt = 2'd0;
        end
    end

    // Entry and occupancy registers; reset clears stored data too.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc0 <= '0;
            r_pc1 <= '0;
            r_in0 <= '0;
            r_in1 <= '0;
            r_cnt <= 2'd0;
        end else begin
            r_pc0 <= w_pc0_nxt;
            r_pc1 <= w_pc1_nxt;
            r_in0 <= w_in0_nxt;
            r_in1 <= w_in1_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_pc    = r_pc0;
    assign o_instr = r_in0;
    assign o_count = r_cnt;
    assign o_full  = (r_cnt == LP_DEPTH);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: fetch PC, run/halt/error FSM,
// redirect handling and a two-entry prefetch queue.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic               misalign_err
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_err;

    logic [1:0] w_count;
    logic       w_full;
    logic       w_pop;
    logic       w_fetch;
    logic       w_redir;
    logic       w_misalign;
    logic       w_redir_ok;

    // Redirects are dead once in ERR; the low address bits decide
    // between a clean jump and an error.
    assign w_redir    = redirect_valid && (r_state != ST_ERR);
    assign w_misalign = w_redir && (redirect_pc[1:0] != 2'b00);
    assign w_redir_ok = w_redir && !w_misalign;

    assign out_valid = (w_count != 2'd0) && (r_state != ST_ERR);
    assign w_pop     = out_valid && out_ready;

    assign w_fetch = !reset
                   && (r_state == ST_RUN)
                   && !halt
                   && !redirect_valid
                   && (!w_full || w_pop);

    assign imem_en      = w_fetch;
    assign imem_addr    = r_pc;
    assign misalign_err = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: redirects take precedence over halt transitions.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_misalign) begin
                    w_state_nxt = ST_ERR;
                end else if (!w_redir && halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (w_misalign) begin
                    w_state_nxt = ST_ERR;
                end else if (!w_redir && !halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Fetch PC: jump on a clean redirect, else advance (wrapping) on fetch.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redir_ok) begin
            w_pc_nxt = redirect_pc;
        end else if (w_fetch) begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    // Fetch PC and sticky misalignment flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_err <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_misalign) begin
                r_err <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_pc    (out_pc),
        .o_instr (out_instr),
        .o_count (w_count),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller.
// Memory word at byte address a is 32'hA000_0000 + (a >> 2).
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        misalign_err;

    int n_checks;
    int n_errs;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        hlt;
        logic        rdy;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_err;
    } vec_t;

    vec_t vecs[29];

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .misalign_err   (misalign_err)
    );

    assign imem_rdata = 32'hA000_0000 + (imem_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    function automatic vec_t mk(
        input logic rst, input logic rv, input logic [31:0] rpc,
        input logic hlt, input logic rdy,
        input logic en, input logic [31:0] addr,
        input logic vld, input logic cd,
        input logic [31:0] pc, input logic [31:0] ins,
        input logic err);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
        v.e_en = en; v.e_addr = addr; v.e_valid = vld; v.chk_data = cd;
        v.e_pc = pc; v.e_instr = ins; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rv,
                         input logic [31:0] rpc, input logic hlt,
                         input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = hlt;
        out_ready      = rdy;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        halt = 1'b0; out_ready = 1'b1;
        next_cycle();
        next_cycle();

        //            rst rv  rpc            h  r   en addr          v  cd pc             instr               err
        vecs[0]  = mk(1, 0, 32'h0,         0, 1,  0, 32'h0,        0, 1, 32'h0,        32'h0,              0);
        vecs[1]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h0,        0, 1, 32'h0,        32'h0,              0);
        vecs[2]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h4,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[3]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h8,        1, 1, 32'h4,        32'hA000_0001,      0);
        vecs[4]  = mk(1, 0, 32'h0,         0, 0,  0, 32'hC,        1, 1, 32'h8,        32'hA000_0002,      0);
        vecs[5]  = mk(0, 0, 32'h0,         0, 0,  1, 32'h0,        0, 1, 32'h0,        32'h0,              0);
        vecs[6]  = mk(0, 0, 32'h0,         0, 0,  1, 32'h4,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[7]  = mk(0, 0, 32'h0,         0, 0,  0, 32'h8,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[8]  = mk(0, 0, 32'h0,         0, 0,  0, 32'h8,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[9]  = mk(0, 0, 32'h0,         0, 0,  0, 32'h8,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[10] = mk(0, 1, 32'h100,       0, 1,  0, 32'h8,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[11] = mk(0, 0, 32'h0,         0, 1,  1, 32'h100,      0, 0, 32'h0,        32'h0,              0);
        vecs[12] = mk(0, 0, 32'h0,         0, 1,  1, 32'h104,      1, 1, 32'h100,      32'hA000_0040,      0);
        vecs[13] = mk(0, 0, 32'h0,         0, 0,  1, 32'h108,      1, 1, 32'h104,      32'hA000_0041,      0);
        vecs[14] = mk(0, 0, 32'h0,         1, 1,  0, 32'h10C,      1, 1, 32'h104,      32'hA000_0041,      0);
        vecs[15] = mk(0, 0, 32'h0,         1, 1,  0, 32'h10C,      1, 1, 32'h108,      32'hA000_0042,      0);
        vecs[16] = mk(0, 0, 32'h0,         1, 1,  0, 32'h10C,      0, 0, 32'h0,        32'h0,              0);
        vecs[17] = mk(0, 0, 32'h0,         0, 1,  0, 32'h10C,      0, 0, 32'h0,        32'h0,              0);
        vecs[18] = mk(0, 0, 32'h0,         0, 1,  1, 32'h10C,      0, 0, 32'h0,        32'h0,              0);
        vecs[19] = mk(0, 0, 32'h0,         0, 1,  1, 32'h110,      1, 1, 32'h10C,      32'hA000_0043,      0);
        vecs[20] = mk(0, 1, 32'hFFFF_FFFC, 0, 1,  0, 32'h114,      1, 1, 32'h110,      32'hA000_0044,      0);
        vecs[21] = mk(0, 0, 32'h0,         0, 1,  1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0,              0);
        vecs[22] = mk(0, 0, 32'h0,         0, 1,  1, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'hDFFF_FFFF,     0);
        vecs[23] = mk(0, 0, 32'h0,         0, 1,  1, 32'h4,        1, 1, 32'h0,        32'hA000_0000,      0);
        vecs[24] = mk(0, 1, 32'h102,       0, 0,  0, 32'h8,        1, 1, 32'h4,        32'hA000_0001,      0);
        vecs[25] = mk(0, 1, 32'h200,       0, 1,  0, 32'h8,        0, 0, 32'h0,        32'h0,              1);
        vecs[26] = mk(0, 0, 32'h0,         0, 1,  0, 32'h8,        0, 0, 32'h0,        32'h0,              1);
        vecs[27] = mk(1, 0, 32'h0,         0, 1,  0, 32'h8,        0, 0, 32'h0,        32'h0,              1);
        vecs[28] = mk(0, 0, 32'h0,         0, 1,  1, 32'h0,        0, 1, 32'h0,        32'h0,              0);

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc,
                  vecs[i].hlt, vecs[i].rdy);
            chk($sformatf("v%0d imem_en", i), 32'(imem_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(vecs[i].e_err));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].e_instr);
            end
            next_cycle();
        end

        // Fill to two entries, then push+pop at full must keep order.
        drive(0, 0, 32'h0, 0, 0);
        chk("fill out_pc", out_pc, 32'h0);
        chk("fill imem_addr", imem_addr, 32'h4);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 32'h0, 0, 1);
            chk($sformatf("order%0d valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("order%0d out_pc", k), out_pc, 32'(4 * k));
            chk($sformatf("order%0d out_instr", k), out_instr, mw(32'(4 * k)));
            chk($sformatf("order%0d imem_en", k), 32'(imem_en), 32'd1);
            next_cycle();
        end

        // Aligned redirect together with halt keeps RUN; fetch resumes
        // at the target as soon as halt drops.
        drive(0, 1, 32'h40, 1, 0);
        chk("rh imem_en", 32'(imem_en), 32'd0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1);
        chk("rh2 out_valid", 32'(out_valid), 32'd0);
        chk("rh2 imem_en", 32'(imem_en), 32'd1);
        chk("rh2 imem_addr", imem_addr, 32'h40);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1);
        chk("rh3 out_valid", 32'(out_valid), 32'd1);
        chk("rh3 out_pc", out_pc, 32'h40);
        chk("rh3 out_instr", out_instr, mw(32'h40));
        next_cycle();

        // Reset mid-stream overrides a redirect and halt in the same cycle.
        drive(1, 1, 32'h102, 1, 1);
        chk("rst imem_en", 32'(imem_en), 32'd0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1);
        chk("rst2 out_valid", 32'(out_valid), 32'd0);
        chk("rst2 misalign_err", 32'(misalign_err), 32'd0);
        chk("rst2 imem_addr", imem_addr, 32'h0);
        chk("rst2 imem_en", 32'(imem_en), 32'd1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
